// File: rtl/simd_mult_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simd_mult_pkg : shared lane constants, handshake types, credit width |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package simd_mult_pkg;

  localparam int NUM_LANES = 2;

  // Request side: requester valid, engine ready.
  typedef struct packed {
    logic valid;
    logic ready;
  } lane_req_t;

  // Response side: engine valid, consumer ready.
  typedef struct packed {
    logic valid;
    logic ready;
  } lane_rsp_t;

  // Counters spanning 0..depth inclusive.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/simd_lane_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simd_lane_fifo : synchronous FIFO with occupancy count, zero when empty |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module simd_lane_fifo
  import simd_mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = credit_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             not_empty, pop;

  assign not_empty = (count_q != '0);
  assign pop       = rd_en_i & not_empty;

  always_comb begin
    count_d = count_q;
    if (wr_en_i && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !wr_en_i) count_d = count_q - CNT_W'(1);
  end

  // Depth is a power of two, so pointers wrap on natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always @(posedge clk_i) begin
    if (rst_ni) assert (!(wr_en_i && count_q == CNT_W'(DEPTH)));
  end

  assign rd_data_o = not_empty ? mem_q[rd_ptr_q] : '0;
  assign count_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/simd_mult_pair_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simd_mult_pair_engine : two-lane credit-controlled multiply responder |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module simd_mult_pair_engine
  import simd_mult_pkg::*;
#(
  parameter int A_W        = 8,
  parameter int B_W        = 8,
  parameter int Z_W        = 16,
  parameter int SIGNED     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clock_i,
  input  logic           reset_n_i,
  input  logic [A_W-1:0] a0_i,
  input  logic [B_W-1:0] b0_i,
  input  logic           valid0_i,
  output logic           ready0_o,
  output logic [Z_W-1:0] z0_o,
  output logic           z_valid0_o,
  input  logic           z_ready0_i,
  input  logic [A_W-1:0] a1_i,
  input  logic [B_W-1:0] b1_i,
  input  logic           valid1_i,
  output logic           ready1_o,
  output logic [Z_W-1:0] z1_o,
  output logic           z_valid1_o,
  input  logic           z_ready1_i
);
  localparam int CW = credit_w(FIFO_DEPTH);

  logic [A_W-1:0]       a_in  [NUM_LANES];
  logic [B_W-1:0]       b_in  [NUM_LANES];
  logic [Z_W-1:0]       z_out [NUM_LANES];
  logic [NUM_LANES-1:0] valid_in, z_ready_in, ready_out, z_valid_out;

  assign a_in[0]    = a0_i;
  assign a_in[1]    = a1_i;
  assign b_in[0]    = b0_i;
  assign b_in[1]    = b1_i;
  assign valid_in   = {valid1_i, valid0_i};
  assign z_ready_in = {z_ready1_i, z_ready0_i};

  assign ready0_o   = ready_out[0];
  assign ready1_o   = ready_out[1];
  assign z_valid0_o = z_valid_out[0];
  assign z_valid1_o = z_valid_out[1];
  assign z0_o       = z_out[0];
  assign z1_o       = z_out[1];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lane_req_t      req;
    lane_rsp_t      rsp;
    logic           accept, pop;
    logic [CW-1:0]  credit_q, credit_d;
    logic           s1_valid_q;
    logic [A_W-1:0] s1_a_q;
    logic [B_W-1:0] s1_b_q;
    logic [Z_W-1:0] prod;
    logic [CW-1:0]  fifo_count;

    assign req    = '{valid: valid_in[l], ready: ready_out[l]};
    assign rsp    = '{valid: z_valid_out[l], ready: z_ready_in[l]};
    assign accept = req.valid & req.ready;
    assign pop    = rsp.valid & rsp.ready;

    // Credits count free slots across stage 1 plus the queue, so the
    // queue can never be written while full.
    assign ready_out[l]   = (credit_q != '0);
    assign z_valid_out[l] = (fifo_count != '0);

    always_comb begin
      credit_d = credit_q;
      if (accept && !pop)      credit_d = credit_q - CW'(1);
      else if (pop && !accept) credit_d = credit_q + CW'(1);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        credit_q   <= CW'(FIFO_DEPTH);
        s1_valid_q <= 1'b0;
        s1_a_q     <= '0;
        s1_b_q     <= '0;
      end else begin
        credit_q   <= credit_d;
        s1_valid_q <= accept;
        if (accept) begin
          s1_a_q <= a_in[l];
          s1_b_q <= b_in[l];
        end
      end
    end

    if (SIGNED != 0) begin : g_signed
      assign prod = $signed({{B_W{s1_a_q[A_W-1]}}, s1_a_q})
                  * $signed({{A_W{s1_b_q[B_W-1]}}, s1_b_q});
    end else begin : g_unsigned
      assign prod = {{B_W{1'b0}}, s1_a_q} * {{A_W{1'b0}}, s1_b_q};
    end

    simd_lane_fifo #(
      .WIDTH (Z_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CW)
    ) u_fifo (
      .clk_i     (clock_i),
      .rst_ni    (reset_n_i),
      .wr_en_i   (s1_valid_q),
      .wr_data_i (prod),
      .rd_en_i   (z_ready_in[l]),
      .rd_data_o (z_out[l]),
      .count_o   (fifo_count)
    );
  end

endmodule
`default_nettype wire

// File: doc/simd_mult_pair_engine.md
Name: simd_mult_pair_engine

Overview:
- Shared two-lane multiply responder. Two independent requesters each submit A_W x B_W operand pairs over valid/ready.
- Both lanes are computed in one fractured (SIMD) multiply pipeline. Each lane gets its product back through its own output queue.
- It is the service side of packed-multiplier users: requesters see a simple handshake, and the block handles registering, pairing and flow control.

Parameters:
- A_W, 8, operand A width per lane
- B_W, 8, operand B width per lane
- Z_W, 16, product width; must equal A_W+B_W
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands (both lanes)
- FIFO_DEPTH, 4, per-lane output queue depth; power of 2, at least 2

Ports:
- clock_i  in  1  sole clock, rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- a0_i  in  A_W  lane 0 operand A
- b0_i  in  B_W  lane 0 operand B
- valid0_i  in  1  lane 0 request valid
- ready0_o  out  1  lane 0 request accepted when valid0_i and ready0_o are both high
- z0_o  out  Z_W  lane 0 product
- z_valid0_o  out  1  lane 0 product valid
- z_ready0_i  in  1  lane 0 consumer pop
- a1_i, b1_i, valid1_i, ready1_o, z1_o, z_valid1_o, z_ready1_i: same as lane 0, for lane 1

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - z_valid*_o = 0, z*_o = 0.
  - Pipeline valid bits cleared; queues emptied.
  - Credits = FIFO_DEPTH, so ready*_o = 1 from the first cycle after release.
- Reset asserted mid-operation discards all in-flight and queued results. No partial output.
- Handshake per lane:
  - Accept on the rising edge where valid and ready are both high.
  - Requester must hold valid and operands stable until accepted; the bench asserts this.
  - Output side pops when z_valid and z_ready are both high.
  - z*_o is held stable while z_valid is high and z_ready is low.
- Pipeline:
  - Stage 1 (edge N): accepted operands of both lanes are registered together with a per-lane valid bit. A lane with no accept is marked invalid in that slot.
  - Stage 2 (edge N+1): lane-wise products are computed from the stage-1 registers and written into the lane's queue, only if that lane's stage-1 valid bit is set.
  - Latency: accept at edge N, so z_valid goes high after edge N+1 when the queue was empty.
  - Throughput: 1 result per lane per cycle when the consumer is ready.
- Arithmetic:
  - SIGNED=0: z = a*b, zero-extended operands.
  - SIGNED=1: z = $signed(a)*$signed(b), full Z_W result.
  - No saturation, rounding or shifting. The result is exact.
- Flow control: one credit counter per lane, range 0..FIFO_DEPTH.
  - Accept only: credit decrements.
  - Pop only: credit increments.
  - Accept and pop in the same cycle: credit unchanged.
  - ready*_o = (credit != 0). It is registered-independent of z_ready (no combinational path from z_ready to ready).
- Queue full: credit is 0 and ready is low, so overflow is impossible by construction. A queue write while full is an assertion failure.
- Queue empty: z_valid is low; pop is ignored.
- Ordering:
  - Per-lane results come out in acceptance order.
  - Lanes are fully independent. A stalled lane never blocks the other lane.
- Pointers wrap modulo FIFO_DEPTH. A full/empty ambiguity is not allowed: use a count or an extra pointer bit.

Decomposition:
- Shared package simd_mult_pkg:
  - lane count constant NUM_LANES = 2
  - per-lane request/response struct typedefs
  - credit width function clog2(FIFO_DEPTH+1)
- One natural sub-module: simd_lane_fifo, a parameterised synchronous FIFO with width, depth and count output. It is instantiated once per lane.
- Top level holds the stage-1 registers, lane multiplies and credit counters.

Test Plan:
- Unsigned max: SIGNED=0, lane0 a=0xFF b=0xFF, lane1 a=0x03 b=0x05, same cycle → z0=0xFE01, z1=0x000F, both valid one cycle after accept.
- Signed corner: SIGNED=1, lane0 a=0x80 b=0x7F → z0=0xC080 (-16256); lane1 a=0xFF b=0xFF → z1=0x0001.
- Backpressure:
  - z_ready0_i=0, lane0 offers 5 requests → exactly 4 accepted, then ready0_o=0.
  - Raise z_ready0_i → 4 results in order, then the 5th is accepted and returned.
  - Lane1 keeps streaming 1/cycle throughout.
- Simultaneous push/pop at credit 0 → ready0_o stays 0 that cycle. Next cycle credit=1 and ready0_o=1. No loss or duplication over 100 random cycles against a scoreboard.
- Reset mid-flight: 3 results queued plus 1 in stage 1, pulse reset_n_i low asynchronously (not clock-aligned) → z_valid*_o=0 immediately. After release, ready*_o=1 and no stale results appear.
- Random soak: 10k cycles, random valid/ready on both lanes, both SIGNED settings → every product matches the reference model, per-lane order is preserved, and credits never exceed FIFO_DEPTH.
